spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_spi_slave.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
//   SPI slave for all four CPOL/CPHA modes. All serial inputs are oversampled
//   in the clk_i domain, and words are shifted LSB first in both directions.
//   A single-entry TX holding register feeds the transmit shifter at the start
//   of every word. Back-to-back words inside one ss-low window are supported.
//
// Ports
//   clk_i, rst_i          core clock, async active-low reset
//   cpol_i, cpha_i        SPI mode (static while ss_i is low)
//   sck_i, ss_i, mosi_i   SPI master signals (asynchronous to clk_i)
//   miso_o, miso_oe_o     slave data out and its output enable
//   txdata_i, tx_wr_i     TX holding register write port
//   tx_full_o             TX holding register occupied
//   rxdata_o, rx_valid_o  last received word and its one-cycle update pulse
//   tx_underrun_o         a word was clocked out with no data loaded
//   abort_o               ss released in the middle of a word
//   buzy                  synchronized ss is low
// -----------------------------------------------------------------------------
module spi_slave #(
  parameter int unsigned DATA_SIZE = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cpol_i,
  input  logic                 cpha_i,
  input  logic                 sck_i,
  input  logic                 ss_i,
  input  logic                 mosi_i,
  output logic                 miso_o,
  output logic                 miso_oe_o,
  input  logic [DATA_SIZE-1:0] txdata_i,
  input  logic                 tx_wr_i,
  output logic                 tx_full_o,
  output logic [DATA_SIZE-1:0] rxdata_o,
  output logic                 rx_valid_o,
  output logic                 tx_underrun_o,
  output logic                 abort_o,
  output logic                 buzy
);

  localparam int unsigned CNT_W = $clog2(DATA_SIZE + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_XFER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Synchronizers (2 flops) plus a delay flop for edge detection
  logic r_sck_s1, r_sck_s2, r_sck_d;
  logic r_ss_s1,  r_ss_s2,  r_ss_d;
  logic r_mosi_s1, r_mosi_s2;

  // Datapath registers
  logic [DATA_SIZE-1:0] r_hold;
  logic                 r_tx_full;
  logic [DATA_SIZE-1:0] r_tx_shift;
  logic [DATA_SIZE-1:0] r_rx_shift;
  logic [DATA_SIZE-1:0] r_rxdata;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_miso;
  logic                 r_rx_valid;
  logic                 r_tx_underrun;
  logic                 r_underrun_pend;
  logic                 r_abort;

  // Edge decode and FSM control strobes
  logic                 w_ss_fall;
  logic                 w_lead;
  logic                 w_trail;
  logic                 w_sample_edge;
  logic                 w_shift_edge;
  logic                 w_last_bit;
  logic                 w_cnt_zero;
  logic [DATA_SIZE-1:0] w_load_word;
  logic                 w_load;
  logic                 w_sample;
  logic                 w_shift;
  logic                 w_first_edge;
  logic                 w_done;
  logic                 w_abort;
  logic                 w_clr_cnt;
  logic                 w_idle;

  // Input synchronizers; ss resets deasserted, sck resets low
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_sck_s1  <= 1'b0;
      r_sck_s2  <= 1'b0;
      r_sck_d   <= 1'b0;
      r_ss_s1   <= 1'b1;
      r_ss_s2   <= 1'b1;
      r_ss_d    <= 1'b1;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
    end else begin
      r_sck_s1  <= sck_i;
      r_sck_s2  <= r_sck_s1;
      r_sck_d   <= r_sck_s2;
      r_ss_s1   <= ss_i;
      r_ss_s2   <= r_ss_s1;
      r_ss_d    <= r_ss_s2;
      r_mosi_s1 <= mosi_i;
      r_mosi_s2 <= r_mosi_s1;
    end
  end

  // Edge decode: leading edge leaves the idle level, trailing edge returns to it
  always_comb begin
    w_ss_fall     = r_ss_d & ~r_ss_s2;
    w_lead        = (r_sck_s2 != cpol_i) && (r_sck_d == cpol_i);
    w_trail       = (r_sck_s2 == cpol_i) && (r_sck_d != cpol_i);
    w_sample_edge = cpha_i ? w_trail : w_lead;
    w_shift_edge  = cpha_i ? w_lead  : w_trail;
    w_last_bit    = (r_cnt == CNT_W'(DATA_SIZE - 1));
    w_cnt_zero    = (r_cnt == '0);
    w_load_word   = r_tx_full ? r_hold : '0;
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_ss_fall) begin
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_state_nxt = r_ss_s2 ? S_IDLE : S_XFER;
      end
      S_XFER: begin
        if (r_ss_s2) begin
          w_state_nxt = S_IDLE;
        end else if (w_sample_edge && w_last_bit) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = r_ss_s2 ? S_IDLE : S_LOAD;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM output decode into datapath strobes
  always_comb begin
    w_load       = 1'b0;
    w_sample     = 1'b0;
    w_shift      = 1'b0;
    w_first_edge = 1'b0;
    w_done       = 1'b0;
    w_abort      = 1'b0;
    w_clr_cnt    = 1'b0;
    w_idle       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_idle    = 1'b1;
        w_clr_cnt = 1'b1;
      end
      S_LOAD: begin
        // A select released before any clocking leaves the holding register intact
        w_load    = ~r_ss_s2;
        w_clr_cnt = 1'b1;
      end
      S_XFER: begin
        if (r_ss_s2) begin
          w_clr_cnt = 1'b1;
          w_abort   = ~w_cnt_zero;
        end else begin
          w_sample     = w_sample_edge;
          // In mode cpha=0 a trailing edge before any sample belongs to the
          // previous word's last bit and must not advance the tx shifter.
          w_shift      = w_shift_edge & (cpha_i | ~w_cnt_zero);
          w_first_edge = w_lead & w_cnt_zero;
        end
      end
      S_DONE: begin
        w_done = 1'b1;
      end
      default: begin
        w_idle = 1'b1;
      end
    endcase
  end

  // TX holding register; a write in the LOAD cycle lands after the load
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_hold    <= '0;
      r_tx_full <= 1'b0;
    end else begin
      if (w_load) begin
        r_tx_full <= 1'b0;
      end
      if (tx_wr_i && !r_tx_full) begin
        r_hold    <= txdata_i;
        r_tx_full <= 1'b1;
      end
    end
  end

  // TX shifter and MISO; cpha=0 presents bit 0 during LOAD, cpha=1 on the first leading edge
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_tx_shift <= '0;
      r_miso     <= 1'b0;
    end else if (w_load) begin
      if (!cpha_i) begin
        r_miso     <= w_load_word[0];
        r_tx_shift <= w_load_word >> 1;
      end else begin
        r_tx_shift <= w_load_word;
      end
    end else if (w_shift) begin
      r_miso     <= r_tx_shift[0];
      r_tx_shift <= r_tx_shift >> 1;
    end else if (w_idle) begin
      r_miso <= 1'b0;
    end
  end

  // RX shifter and bit counter
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rx_shift <= '0;
      r_cnt      <= '0;
    end else begin
      if (w_sample) begin
        r_rx_shift <= {r_mosi_s2, r_rx_shift[DATA_SIZE-1:1]};
      end
      if (w_clr_cnt) begin
        r_cnt <= '0;
      end else if (w_sample) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Received word and status pulses
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rxdata   <= '0;
      r_rx_valid <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      r_rx_valid <= w_done;
      r_abort    <= w_abort;
      if (w_done) begin
        r_rxdata <= r_rx_shift;
      end
    end
  end

  // Underrun is flagged at LOAD but reported only once the word actually
  // starts clocking, so the speculative LOAD after a final word stays silent.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_underrun_pend <= 1'b0;
      r_tx_underrun   <= 1'b0;
    end else begin
      r_tx_underrun <= w_first_edge & r_underrun_pend;
      if (w_load) begin
        r_underrun_pend <= ~r_tx_full;
      end else if (w_first_edge || (r_state != S_XFER)) begin
        r_underrun_pend <= 1'b0;
      end
    end
  end

  assign miso_oe_o     = ~r_ss_s2;
  assign miso_o        = r_miso & ~r_ss_s2;
  assign buzy          = ~r_ss_s2;
  assign tx_full_o     = r_tx_full;
  assign rxdata_o      = r_rxdata;
  assign rx_valid_o    = r_rx_valid;
  assign tx_underrun_o = r_tx_underrun;
  assign abort_o       = r_abort;

endmodule

// File: tb/tb_spi_slave.sv
`timescale 1ns/1ps
// Directed bench for spi_slave (DATA_SIZE=8) with a behavioural SPI master.
module tb_spi_slave;

  localparam int HALF = 80;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic       sck = 1'b0;
  logic       ss = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic       miso_oe;
  logic [7:0] txdata = 8'h00;
  logic       tx_wr = 1'b0;
  logic       tx_full;
  logic [7:0] rxdata;
  logic       rx_valid;
  logic       tx_underrun;
  logic       abort_p;
  logic       buzy;

  int n_tests = 0;
  int n_fail  = 0;
  int n_rx = 0;
  int n_ur = 0;
  int n_ab = 0;
  logic [7:0] rx_q[$];

  always #5 clk = ~clk;

  spi_slave #(.DATA_SIZE(8)) dut (
    .clk_i(clk), .rst_i(rst), .cpol_i(cpol), .cpha_i(cpha),
    .sck_i(sck), .ss_i(ss), .mosi_i(mosi),
    .miso_o(miso), .miso_oe_o(miso_oe),
    .txdata_i(txdata), .tx_wr_i(tx_wr), .tx_full_o(tx_full),
    .rxdata_o(rxdata), .rx_valid_o(rx_valid),
    .tx_underrun_o(tx_underrun), .abort_o(abort_p), .buzy(buzy)
  );

  // Pulse monitor, sampled on the inactive clock edge
  always @(negedge clk) begin
    if (rx_valid) begin
      n_rx++;
      rx_q.push_back(rxdata);
    end
    if (tx_underrun) n_ur++;
    if (abort_p) n_ab++;
  end

  task automatic tx_write(input logic [7:0] v);
    @(negedge clk);
    txdata = v;
    tx_wr  = 1'b1;
    @(negedge clk);
    tx_wr  = 1'b0;
  endtask

  task automatic ss_start(input logic pol, input logic pha);
    cpol = pol;
    cpha = pha;
    sck  = pol;
    #(HALF);
    ss = 1'b0;
    #(HALF);
  endtask

  task automatic ss_end();
    ss = 1'b1;
    #(2 * HALF);
  endtask

  // Clock nbits of a word, LSB first, returning what MISO showed per bit
  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi = tx[i];
        #(HALF);
        got[i] = miso;
        sck = ~cpol;
        #(HALF);
        sck = cpol;
      end else begin
        #(HALF);
        sck  = ~cpol;
        mosi = tx[i];
        #(HALF);
        got[i] = miso;
        sck = cpol;
      end
    end
    #(HALF);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #23;
    if ({miso, miso_oe, tx_full, rx_valid, tx_underrun, abort_p, buzy} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_flags got=%b want=0000000",
               {miso, miso_oe, tx_full, rx_valid, tx_underrun, abort_p, buzy});
    end
    n_tests++;
    if (rxdata !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_rxdata got=%h want=00", rxdata);
    end
    n_tests++;
    rst = 1'b1;
    #(HALF);
  endtask

  task automatic test_mode0();
    logic [7:0] got;
    int b_rx, b_ur;
    tx_write(8'hA5);
    #1;
    if (tx_full !== 1'b1) begin
      n_fail++;
      $display("FAIL mode0_txfull_set got=%b want=1", tx_full);
    end
    n_tests++;
    b_rx = n_rx; b_ur = n_ur;
    ss_start(1'b0, 1'b0);
    if (miso_oe !== 1'b1 || buzy !== 1'b1 || tx_full !== 1'b0) begin
      n_fail++;
      $display("FAIL mode0_selected oe=%b buzy=%b full=%b want=1 1 0", miso_oe, buzy, tx_full);
    end
    n_tests++;
    spi_bits(8'h3C, 8, got);
    ss_end();
    if (got !== 8'hA5) begin
      n_fail++;
      $display("FAIL mode0_miso got=%h want=a5", got);
    end
    n_tests++;
    if (rxdata !== 8'h3C) begin
      n_fail++;
      $display("FAIL mode0_rxdata got=%h want=3c", rxdata);
    end
    n_tests++;
    if (n_rx - b_rx != 1 || n_ur - b_ur != 0) begin
      n_fail++;
      $display("FAIL mode0_pulses rx=%0d ur=%0d want=1 0", n_rx - b_rx, n_ur - b_ur);
    end
    n_tests++;
    if (miso_oe !== 1'b0 || miso !== 1'b0) begin
      n_fail++;
      $display("FAIL mode0_deselect oe=%b miso=%b want=0 0", miso_oe, miso);
    end
    n_tests++;
  endtask

  task automatic test_modes();
    logic [7:0] got;
    int b_rx;
    for (int m = 1; m < 4; m++) begin
      tx_write(8'h81);
      b_rx = n_rx;
      ss_start(m[1], m[0]);
      spi_bits(8'h7E, 8, got);
      ss_end();
      if (got !== 8'h81) begin
        n_fail++;
        $display("FAIL mode%0d_miso got=%h want=81", m, got);
      end
      n_tests++;
      if (rxdata !== 8'h7E || n_rx - b_rx != 1) begin
        n_fail++;
        $display("FAIL mode%0d_rx got=%h pulses=%0d want=7e 1", m, rxdata, n_rx - b_rx);
      end
      n_tests++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] g1, g2;
    int b_rx, b_ur;
    tx_write(8'h11);
    b_rx = n_rx; b_ur = n_ur;
    ss_start(1'b0, 1'b0);
    fork
      spi_bits(8'h22, 8, g1);
      begin
        #(5 * HALF);
        tx_write(8'h33);
      end
    join
    spi_bits(8'h44, 8, g2);
    ss_end();
    if (g1 !== 8'h11 || g2 !== 8'h33) begin
      n_fail++;
      $display("FAIL b2b_miso got=%h %h want=11 33", g1, g2);
    end
    n_tests++;
    if (n_rx - b_rx != 2) begin
      n_fail++;
      $display("FAIL b2b_rx_count got=%0d want=2", n_rx - b_rx);
    end else begin
      if (rx_q[b_rx] !== 8'h22 || rx_q[b_rx + 1] !== 8'h44) begin
        n_fail++;
        $display("FAIL b2b_rxdata got=%h %h want=22 44", rx_q[b_rx], rx_q[b_rx + 1]);
      end
    end
    n_tests++;
    if (n_ur - b_ur != 0) begin
      n_fail++;
      $display("FAIL b2b_underrun got=%0d want=0", n_ur - b_ur);
    end
    n_tests++;
  endtask

  task automatic test_underrun();
    logic [7:0] got;
    int b_rx, b_ur;
    b_rx = n_rx; b_ur = n_ur;
    ss_start(1'b0, 1'b0);
    spi_bits(8'h5A, 8, got);
    ss_end();
    if (n_ur - b_ur != 1) begin
      n_fail++;
      $display("FAIL underrun_count got=%0d want=1", n_ur - b_ur);
    end
    n_tests++;
    if (got !== 8'h00) begin
      n_fail++;
      $display("FAIL underrun_miso got=%h want=00", got);
    end
    n_tests++;
    if (rxdata !== 8'h5A || n_rx - b_rx != 1) begin
      n_fail++;
      $display("FAIL underrun_rx got=%h pulses=%0d want=5a 1", rxdata, n_rx - b_rx);
    end
    n_tests++;
  endtask

  task automatic test_abort();
    logic [7:0] got;
    int b_rx, b_ab;
    tx_write(8'h99);
    b_rx = n_rx; b_ab = n_ab;
    ss_start(1'b0, 1'b0);
    spi_bits(8'hF0, 5, got);
    ss_end();
    if (n_ab - b_ab != 1) begin
      n_fail++;
      $display("FAIL abort_count got=%0d want=1", n_ab - b_ab);
    end
    n_tests++;
    if (n_rx - b_rx != 0 || rxdata !== 8'h5A) begin
      n_fail++;
      $display("FAIL abort_rx pulses=%0d data=%h want=0 5a", n_rx - b_rx, rxdata);
    end
    n_tests++;
    if (buzy !== 1'b0 || got[4:0] !== 5'b11001) begin
      n_fail++;
      $display("FAIL abort_state buzy=%b miso=%b want=0 11001", buzy, got[4:0]);
    end
    n_tests++;
    // Recovery: a full word after the abort
    tx_write(8'h0F);
    b_rx = n_rx;
    ss_start(1'b0, 1'b0);
    spi_bits(8'hE7, 8, got);
    ss_end();
    if (got !== 8'h0F || rxdata !== 8'hE7 || n_rx - b_rx != 1) begin
      n_fail++;
      $display("FAIL abort_recover miso=%h rx=%h pulses=%0d want=0f e7 1", got, rxdata, n_rx - b_rx);
    end
    n_tests++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] got;
    int b_rx, b_ur, b_ab;
    tx_write(8'hC3);
    ss_start(1'b0, 1'b0);
    spi_bits(8'hFF, 3, got);
    rst = 1'b0;
    #7;
    b_rx = n_rx; b_ur = n_ur; b_ab = n_ab;
    if ({miso, miso_oe, tx_full, rx_valid, tx_underrun, abort_p, buzy} !== 7'b0 || rxdata !== 8'h00) begin
      n_fail++;
      $display("FAIL rstmid_outputs flags=%b rx=%h want=0000000 00",
               {miso, miso_oe, tx_full, rx_valid, tx_underrun, abort_p, buzy}, rxdata);
    end
    n_tests++;
    ss = 1'b1;
    #(HALF);
    rst = 1'b1;
    #(2 * HALF);
    if (n_rx != b_rx || n_ur != b_ur || n_ab != b_ab) begin
      n_fail++;
      $display("FAIL rstmid_pulses rx=%0d ur=%0d ab=%0d want=0 0 0", n_rx - b_rx, n_ur - b_ur, n_ab - b_ab);
    end
    n_tests++;
    tx_write(8'h6D);
    b_rx = n_rx;
    ss_start(1'b0, 1'b0);
    spi_bits(8'hB2, 8, got);
    ss_end();
    if (got !== 8'h6D || rxdata !== 8'hB2 || n_rx - b_rx != 1) begin
      n_fail++;
      $display("FAIL rstmid_next miso=%h rx=%h pulses=%0d want=6d b2 1", got, rxdata, n_rx - b_rx);
    end
    n_tests++;
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_modes();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
